// File: rtl/freeway_scene_if.sv
// ============================================================================
// Module  : freeway_scene_if
// Brief   : Pixel-scan, button and object-flag bundle of the freeway renderer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface freeway_scene_if #(
    parameter int SCORE_W = 8
);
    logic               frame_tick;
    logic               cima;
    logic               baixo;
    logic [9:0]         row;
    logic [9:0]         column;
    logic               saida_galinha;
    logic               saida_carro;
    logic               collision;
    logic [SCORE_W-1:0] score;
    logic               hit_active;

    modport master (
        output frame_tick, cima, baixo, row, column,
        input  saida_galinha, saida_carro, collision, score, hit_active
    );

    modport slave (
        input  frame_tick, cima, baixo, row, column,
        output saida_galinha, saida_carro, collision, score, hit_active
    );
endinterface

`default_nettype wire

// File: rtl/freeway_scene.sv
// ============================================================================
// Module  : freeway_scene
// Brief   : Chicken + NUM_LANES vehicle renderer with collision/respawn FSM and
//           crossing score. Define HIT_BLINK_EN to blink the chicken while hit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module freeway_scene #(
    parameter int          NUM_LANES       = 4,
    parameter int          H_RES           = 640,
    parameter int          V_RES           = 480,
    parameter int          CAR_W           = 60,
    parameter int          CAR_H           = 40,
    parameter int          CHICK_SIZE      = 30,
    parameter int          STEP            = 60,
    parameter int          CHICK_START_ROW = 435,
    parameter int          CHICK_COL       = 320,
    parameter int          LANE_ROW0       = 60,
    parameter int          LANE_PITCH      = 100,
    parameter logic [31:0] LANE_SPEEDS     = 32'h0000_4122,
    parameter logic [7:0]  LANE_DIR        = 8'b0000_1010,
    parameter int          HIT_FRAMES      = 30,
    parameter int          SCORE_W         = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    freeway_scene_if.slave  bus
);

    localparam int HIT_CNT_W = $clog2(HIT_FRAMES + 1);

    localparam logic [1:0] S_PLAY    = 2'd0;
    localparam logic [1:0] S_HIT     = 2'd1;
    localparam logic [1:0] S_RESPAWN = 2'd2;

    localparam logic [10:0] c_H_RES       = 11'(H_RES);
    localparam logic [10:0] c_CAR_W       = 11'(CAR_W);
    localparam logic [10:0] c_CAR_H       = 11'(CAR_H);
    localparam logic [10:0] c_CHICK_SIZE  = 11'(CHICK_SIZE);
    localparam logic [10:0] c_STEP        = 11'(STEP);
    localparam logic [10:0] c_START_ROW   = 11'(CHICK_START_ROW);
    localparam logic [10:0] c_CHICK_COL   = 11'(CHICK_COL);
    localparam logic [10:0] c_DOWN_LIMIT  = 11'(V_RES - CHICK_SIZE);
    localparam logic [10:0] c_LEFT_START  = 11'(H_RES - CAR_W);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [10:0]          r_chick_row;
    logic [2:0]           r_up_sync;
    logic [2:0]           r_dn_sync;
    logic                 r_up_req;
    logic                 r_dn_req;
    logic                 r_galinha;
    logic                 r_carro;
    logic                 r_collision;
    logic [SCORE_W-1:0]   r_score;
    logic [HIT_CNT_W-1:0] r_hit_cnt;

    logic [10:0]          w_row;
    logic [10:0]          w_col;
    logic [NUM_LANES-1:0] w_in_lane;
    logic                 w_in_chick;
    logic                 w_blank;
    logic                 w_up_edge;
    logic                 w_dn_edge;
    logic                 w_hit_detect;
    logic                 w_hit_done;
    logic                 w_play;
    logic                 w_in_hit;
    logic                 w_respawn;
    logic                 w_hit_active;

    assign w_row = {1'b0, bus.row};
    assign w_col = {1'b0, bus.column};

    assign w_in_chick = (w_row > r_chick_row) && (w_row < r_chick_row + c_CHICK_SIZE) &&
                        (w_col > c_CHICK_COL) && (w_col < c_CHICK_COL + c_CHICK_SIZE);

    // Vehicles keep moving in every state, so each lane owns its column register.
    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            localparam logic [10:0] c_TOP   = 11'(LANE_ROW0 + i * LANE_PITCH);
            localparam logic [10:0] c_SPEED = 11'(LANE_SPEEDS[4*i +: 4]);
            localparam bit          c_RIGHT = LANE_DIR[i];

            logic [10:0] r_col;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_col <= c_RIGHT ? 11'd0 : c_LEFT_START;
                end else if (bus.frame_tick) begin
                    if (c_RIGHT) begin
                        if (r_col + c_SPEED >= c_H_RES) r_col <= 11'd0;
                        else                            r_col <= r_col + c_SPEED;
                    end else begin
                        if (r_col <= c_SPEED) r_col <= c_H_RES;
                        else                  r_col <= r_col - c_SPEED;
                    end
                end
            end

            assign w_in_lane[i] = (w_row > c_TOP) && (w_row < c_TOP + c_CAR_H) &&
                                  (w_col > r_col) && (w_col < r_col + c_CAR_W);
        end
    endgenerate

`ifdef HIT_BLINK_EN
    logic [3:0] r_frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               r_frame_cnt <= 4'd0;
        else if (bus.frame_tick) r_frame_cnt <= r_frame_cnt + 4'd1;
    end

    assign w_blank = w_in_hit && r_frame_cnt[3];
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_galinha <= 1'b0;
            r_carro   <= 1'b0;
        end else begin
            r_galinha <= w_in_chick && !w_blank;
            r_carro   <= |w_in_lane;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_up_sync <= 3'd0;
            r_dn_sync <= 3'd0;
        end else begin
            r_up_sync <= {r_up_sync[1:0], bus.cima};
            r_dn_sync <= {r_dn_sync[1:0], bus.baixo};
        end
    end

    assign w_up_edge    = r_up_sync[1] && !r_up_sync[2];
    assign w_dn_edge    = r_dn_sync[1] && !r_dn_sync[2];
    assign w_hit_detect = (r_state == S_PLAY) && r_galinha && r_carro;
    assign w_hit_done   = (r_hit_cnt == HIT_CNT_W'(HIT_FRAMES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_PLAY;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PLAY:    if (w_hit_detect) w_state_next = S_HIT;
            S_HIT:     if (w_hit_done)   w_state_next = S_RESPAWN;
            S_RESPAWN: w_state_next = S_PLAY;
            default:   w_state_next = S_PLAY;
        endcase
    end

    always_comb begin
        w_play       = 1'b0;
        w_in_hit     = 1'b0;
        w_respawn    = 1'b0;
        w_hit_active = 1'b0;
        case (r_state)
            S_PLAY:    w_play = 1'b1;
            S_HIT:     begin w_in_hit  = 1'b1; w_hit_active = 1'b1; end
            S_RESPAWN: begin w_respawn = 1'b1; w_hit_active = 1'b1; end
            default:   w_play = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt   <= '0;
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_hit_detect;
            if (w_hit_detect)
                r_hit_cnt <= '0;
            else if (w_in_hit && bus.frame_tick && !w_hit_done)
                r_hit_cnt <= r_hit_cnt + HIT_CNT_W'(1);
        end
    end

    // A tick coinciding with a detected hit discards the pending move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chick_row <= c_START_ROW;
            r_up_req    <= 1'b0;
            r_dn_req    <= 1'b0;
            r_score     <= '0;
        end else if (w_respawn) begin
            r_chick_row <= c_START_ROW;
            r_up_req    <= 1'b0;
            r_dn_req    <= 1'b0;
        end else if (!w_play || w_hit_detect) begin
            r_up_req    <= 1'b0;
            r_dn_req    <= 1'b0;
        end else if (bus.frame_tick) begin
            r_up_req    <= 1'b0;
            r_dn_req    <= 1'b0;
            if (r_up_req && !r_dn_req) begin
                if (r_chick_row >= c_STEP) begin
                    r_chick_row <= r_chick_row - c_STEP;
                end else begin
                    r_chick_row <= c_START_ROW;
                    if (r_score != '1) r_score <= r_score + SCORE_W'(1);
                end
            end else if (r_dn_req && !r_up_req) begin
                if (r_chick_row + c_STEP <= c_DOWN_LIMIT)
                    r_chick_row <= r_chick_row + c_STEP;
            end
        end else begin
            r_up_req    <= r_up_req || w_up_edge;
            r_dn_req    <= r_dn_req || w_dn_edge;
        end
    end

    assign bus.saida_galinha = r_galinha;
    assign bus.saida_carro   = r_carro;
    assign bus.collision     = r_collision;
    assign bus.score         = r_score;
    assign bus.hit_active    = w_hit_active;

endmodule

`default_nettype wire
